down_counter_timer: RTL
=======================

DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 Parameter: WIDTH, default 8, sets the counter and load-value width in bits.
REQ-002 Port: Clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: Reset  input  1  synchronous, active-high reset.
REQ-004 Port: Load  input  1  start/restart request; captures LoadValue on the same edge.
REQ-005 Port: LoadValue  input  WIDTH  unsigned start count.
REQ-006 Port: Enable  input  1  count qualifier; decrements only on edges where Enable=1.
REQ-007 Port: AutoReload  input  1  mode select: 1=periodic reload, 0=one-shot; sampled only at terminal count.
REQ-008 Port: Stop  input  1  abort request; returns the block to IDLE.
REQ-009 Port: CounterValue  output  WIDTH  current count, registered.
REQ-010 Port: Busy  output  1  high while state=RUN.
REQ-011 Port: Done  output  1  registered pulse, high for exactly one cycle per terminal-count event.
REQ-012 Port: Expired  output  1  high while state=DONE.

Function
REQ-013 States SHALL be IDLE, RUN and DONE; Busy and Expired SHALL decode directly from state.
REQ-014 Edge priority SHALL be Reset > Load > Stop > count.
REQ-015 Load=1 in any state with LoadValue!=0: reload register and CounterValue <= LoadValue, state <= RUN, Done <= 0.
REQ-016 Load=1 with LoadValue=0: CounterValue <= 0, reload register <= 0, state <= DONE, Done <= 1, regardless of AutoReload.
REQ-017 Stop=1 (no Load) in RUN or DONE: state <= IDLE, CounterValue held; no Done pulse.
REQ-018 RUN, Enable=0: CounterValue, state and reload register held; Done <= 0.
REQ-019 RUN, Enable=1, CounterValue>1: CounterValue <= CounterValue-1.
REQ-020 Terminal count is RUN, Enable=1, CounterValue=1; on that edge Done <= 1.
REQ-021 At terminal count with AutoReload=0: CounterValue <= 0, state <= DONE.
REQ-022 At terminal count with AutoReload=1: CounterValue <= reload register, state stays RUN, and CounterValue never reads 0.
REQ-023 With AutoReload=1 and reload value 1: Done SHALL be high on every Enable=1 cycle while CounterValue stays 1.
REQ-024 Done SHALL be 0 on every edge that is not a terminal count or a zero-value Load.
REQ-025 Terminal-count latency: Done and the new CounterValue SHALL be visible in the same cycle, one edge after the qualifying state.
REQ-026 IDLE and DONE SHALL ignore Enable; CounterValue is held (DONE holds 0).
REQ-027 Load coincident with terminal count: the Load SHALL win, with no Done pulse.
REQ-028 The counter SHALL never underflow below 0 and never exceed the loaded value.
REQ-029 Load and Stop SHALL be level-sampled per edge; holding Load high re-loads every cycle, so CounterValue stays at LoadValue.

Reset
REQ-030 Reset=1 at an edge: state <= IDLE, CounterValue <= 0, reload register <= 0, Done <= 0; hence Busy=0 and Expired=0.
REQ-031 Reset SHALL override Load, Stop and Enable, including mid-count and during a Done pulse.
REQ-032 After Reset deasserts, the block SHALL remain in IDLE until a Load.

Verification
REQ-033 Reset, Load LoadValue=3, Enable=1, AutoReload=0 -> CounterValue 3,2,1,0; Done=1 only in the cycle CounterValue=0; then Expired=1, Busy=0, value held at 0.
REQ-034 Load LoadValue=2, AutoReload=1, Enable=1 -> CounterValue 2,1,2,1,...; Done=1 in each cycle the value returns to 2; Busy stays 1.
REQ-035 Load 4, Enable pattern 1,0,0,1 -> CounterValue 4,3,3,3,2; Done=0 throughout.
REQ-036 Load 5, two enabled cycles (value 3), Reset=1 one cycle -> CounterValue=0, Busy=0, Expired=0, Done=0; Enable alone then has no effect.
REQ-037 Load LoadValue=0 -> next cycle Expired=1, Done=1 for one cycle, CounterValue=0; subsequent Stop -> IDLE, Expired=0.
REQ-038 RUN at CounterValue=1 with Enable=1, Load=1 and LoadValue=7 on the same edge -> CounterValue=7, Done=0, Busy=1; a separate Stop in RUN -> IDLE with value held.

Source files
------------

// File: rtl/down_counter_timer_if.sv
// rtl/down_counter_timer_if.sv - control and status bundle for down_counter_timer
interface down_counter_timer_if #(
  parameter int WIDTH = 8
);
  logic             Load;
  logic [WIDTH-1:0] LoadValue;
  logic             Enable;
  logic             AutoReload;
  logic             Stop;
  logic [WIDTH-1:0] CounterValue;
  logic             Busy;
  logic             Done;
  logic             Expired;

  modport master (
    output Load, LoadValue, Enable, AutoReload, Stop,
    input  CounterValue, Busy, Done, Expired
  );

  modport slave (
    input  Load, LoadValue, Enable, AutoReload, Stop,
    output CounterValue, Busy, Done, Expired
  );
endinterface

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable down counter with one-shot / periodic reload
module down_counter_timer #(
  parameter int WIDTH = 8
) (
  input logic             Clock,
  input logic             Reset,
  down_counter_timer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic [WIDTH-1:0] reload_q, reload_n;
  logic             done_q, done_n;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      count_q  <= count_n;
      reload_q <= reload_n;
      done_q   <= done_n;
    end
  end

  // Priority below reset: Load, then Stop, then counting in RUN.
  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    reload_n = reload_q;
    done_n   = 1'b0;
    if (bus.Load) begin
      reload_n = bus.LoadValue;
      count_n  = bus.LoadValue;
      if (bus.LoadValue != '0) begin
        state_n = RUN;
      end else begin
        state_n = DONE;
        done_n  = 1'b1;
      end
    end else if (bus.Stop) begin
      state_n = IDLE;
    end else if (state_q == RUN && bus.Enable) begin
      if (count_q > WIDTH'(1)) begin
        count_n = count_q - WIDTH'(1);
      end else if (count_q == WIDTH'(1)) begin
        done_n = 1'b1;
        // AutoReload is only consulted here, at the terminal count.
        if (bus.AutoReload) begin
          count_n = reload_q;
        end else begin
          count_n = '0;
          state_n = DONE;
        end
      end
    end
  end

  assign bus.CounterValue = count_q;
  assign bus.Done         = done_q;
  assign bus.Busy         = (state_q == RUN);
  assign bus.Expired      = (state_q == DONE);
endmodule
